// File: rtl/gene_net_stepper.sv
// gene_net_stepper: loads an initial gene vector, then iterates a synchronous
// Boolean gene network one step per clock until a 2-cycle, fixed point or step limit.
module gene_net_stepper #(
  parameter int N         = 8,
  parameter int CW        = 4,
  parameter int MAX_STEPS = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   init_val,
  input  logic [N*N-1:0] act_mask,
  input  logic [N*N-1:0] rep_mask,
  input  logic           cycle_flag,
  output logic [N-1:0]   x,
  output logic [CW-1:0]  cnt,
  output logic [N-1:0]   init_val_chk,
  output logic           busy,
  output logic           done,
  output logic           cycle_found,
  output logic           fixed_pt,
  output logic           timeout,
  output logic [2:0]     state_dbg
);

  // Handshake: start is a single-cycle request with no ready; it is taken only
  // in IDLE (busy low, done low) and silently dropped in every other state.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STEPS);
  localparam logic [CW-1:0] CYC_MIN = CW'(2);

  state_t        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  chk_q, chk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          fix_q, fix_d;
  logic          tmo_q, tmo_d;
  logic [N-1:0]  nx;

  // A gene with no activators is constitutive: on unless repressed.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gene
      logic [N-1:0] act_row;
      logic [N-1:0] rep_row;
      logic         act_any;
      logic         rep_any;
      assign act_row = act_mask[gi*N +: N];
      assign rep_row = rep_mask[gi*N +: N];
      assign act_any = |(x_q & act_row);
      assign rep_any = |(x_q & rep_row);
      assign nx[gi]  = (act_row != '0) ? (act_any & ~rep_any) : ~rep_any;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      fix_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      fix_q   <= fix_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    fix_d   = fix_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cyc_d   = 1'b0;
          fix_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Inverted token forces a change on the detector even for a repeated init.
        chk_d   = ~init_val;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        x_d     = init_val;
        cnt_d   = '0;
        chk_d   = init_val;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cycle_flag && (cnt_q > CYC_MIN)) begin
          cyc_d   = 1'b1;
          state_d = S_DONE;
        end else if (nx == x_q) begin
          fix_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == MAX_CNT) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          x_d   = nx;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign x            = x_q;
  assign cnt          = cnt_q;
  assign init_val_chk = chk_q;
  assign cycle_found  = cyc_q;
  assign fixed_pt     = fix_q;
  assign timeout      = tmo_q;
  assign busy         = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_gene_net_stepper.sv
// Bench for gene_net_stepper: a trajectory model predicts every observed cycle of
// each run; an attached period-2 detector model closes the loop on cycle_flag.
module tb_gene_net_stepper;
  localparam int N         = 8;
  localparam int CW        = 4;
  localparam int MAX_STEPS = 15;

  typedef struct packed {
    logic [N-1:0]  x;
    logic [CW-1:0] cnt;
    logic [N-1:0]  chk;
    logic          busy;
    logic          done;
    logic          cyc;
    logic          fix;
    logic          tmo;
  } obs_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           cycle_flag;
  logic           use_det;
  logic [N-1:0]   init_val;
  logic [N*N-1:0] act_mask;
  logic [N*N-1:0] rep_mask;
  logic [N-1:0]   x;
  logic [N-1:0]   init_val_chk;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic           done;
  logic           cycle_found;
  logic           fixed_pt;
  logic           timeout;
  logic [2:0]     state_dbg;

  obs_t exp_q[$];
  obs_t cur_exp;
  obs_t last_exp;
  obs_t pin_exp;
  logic pin_en;
  int   n_cmp = 0;
  int   n_bad = 0;

  gene_net_stepper #(.N(N), .CW(CW), .MAX_STEPS(MAX_STEPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .init_val     (init_val),
    .act_mask     (act_mask),
    .rep_mask     (rep_mask),
    .cycle_flag   (cycle_flag),
    .x            (x),
    .cnt          (cnt),
    .init_val_chk (init_val_chk),
    .busy         (busy),
    .done         (done),
    .cycle_found  (cycle_found),
    .fixed_pt     (fixed_pt),
    .timeout      (timeout),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Detector: history restarts whenever init_val_chk changes; flags x(t)==x(t-2)!=x(t-1).
  logic [N-1:0] h1, h2, chk_s;
  int           hn;
  logic         det_flag;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 <= '0; h2 <= '0; chk_s <= '0; hn <= 0;
    end else begin
      chk_s <= init_val_chk;
      if (init_val_chk != chk_s) begin
        h1 <= x;
        hn <= 1;
      end else begin
        h2 <= h1;
        h1 <= x;
        if (hn < 3) hn <= hn + 1;
      end
    end
  end
  assign det_flag   = (hn >= 2) && (x == h2) && (x != h1);
  assign cycle_flag = use_det & det_flag;

  function automatic logic [N-1:0] next_state(input logic [N-1:0] s);
    logic [N-1:0] r;
    logic [N-1:0] ar;
    logic [N-1:0] rr;
    r = '0;
    for (int i = 0; i < N; i++) begin
      ar = act_mask[i*N +: N];
      rr = rep_mask[i*N +: N];
      if (ar == '0) r[i] = ((s & rr) == '0);
      else          r[i] = ((s & ar) != '0) && ((s & rr) == '0);
    end
    return r;
  endfunction

  // Predicts the observed outputs after every edge from start acceptance to the return to IDLE.
  task automatic build_run(input logic [N-1:0] iv, input logic ud);
    obs_t         e;
    logic [N-1:0] xs[$];
    logic [N-1:0] cur;
    logic [N-1:0] nxt;
    int           k;
    bit           fin;
    e = last_exp;
    e.busy = 1'b1; e.done = 1'b0; e.cyc = 1'b0; e.fix = 1'b0; e.tmo = 1'b0;
    exp_q.push_back(e);
    e.chk = ~iv;
    exp_q.push_back(e);
    e.x = iv; e.cnt = '0; e.chk = iv;
    exp_q.push_back(e);
    xs.push_back(iv);
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      cur = xs[k];
      nxt = next_state(cur);
      if (ud && k > 2 && cur == xs[k-2] && cur != xs[k-1]) begin
        e.cyc = 1'b1; fin = 1'b1;
      end else if (nxt == cur) begin
        e.fix = 1'b1; fin = 1'b1;
      end else if (k == MAX_STEPS) begin
        e.tmo = 1'b1; fin = 1'b1;
      end else begin
        xs.push_back(nxt);
        k++;
        e.x = nxt;
        e.cnt = CW'(k);
        exp_q.push_back(e);
      end
    end
    e.busy = 1'b0; e.done = 1'b1;
    exp_q.push_back(e);
    e.done = 1'b0;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", nm, got, want, $time);
    end
  endtask

  always begin
    @(negedge clk or posedge rst);
    #1;
    if (rst) begin
      exp_q.delete();
      cur_exp = '0;
    end else if (exp_q.size() != 0) begin
      cur_exp = exp_q.pop_front();
    end
    check("x",            32'(x),            32'(cur_exp.x));
    check("cnt",          32'(cnt),          32'(cur_exp.cnt));
    check("init_val_chk", 32'(init_val_chk), 32'(cur_exp.chk));
    check("busy",         32'(busy),         32'(cur_exp.busy));
    check("done",         32'(done),         32'(cur_exp.done));
    check("cycle_found",  32'(cycle_found),  32'(cur_exp.cyc));
    check("fixed_pt",     32'(fixed_pt),     32'(cur_exp.fix));
    check("timeout",      32'(timeout),      32'(cur_exp.tmo));
    if (pin_en && cur_exp.done) begin
      check("pin_x",    32'(x),           32'(pin_exp.x));
      check("pin_cnt",  32'(cnt),         32'(pin_exp.cnt));
      check("pin_chk",  32'(init_val_chk), 32'(pin_exp.chk));
      check("pin_done", 32'(done),        32'(pin_exp.done));
      check("pin_cyc",  32'(cycle_found), 32'(pin_exp.cyc));
      check("pin_fix",  32'(fixed_pt),    32'(pin_exp.fix));
      check("pin_tmo",  32'(timeout),     32'(pin_exp.tmo));
    end
  end

  task automatic set_pin(input logic [N-1:0] px, input int pc, input logic [N-1:0] pk,
                         input logic c, input logic f, input logic t);
    pin_en = 1'b1;
    pin_exp = '0;
    pin_exp.x = px; pin_exp.cnt = CW'(pc); pin_exp.chk = pk;
    pin_exp.done = 1'b1; pin_exp.cyc = c; pin_exp.fix = f; pin_exp.tmo = t;
  endtask

  // Called at negedge+2 in IDLE; optionally pokes a second start while busy.
  task automatic go(input logic [N-1:0] iv, input logic ud, input logic poke);
    init_val = iv;
    use_det  = ud;
    build_run(iv, ud);
    start = 1'b1;
    @(negedge clk); #2; start = 1'b0;
    if (poke) begin
      @(negedge clk); #2; start = 1'b1;
      @(negedge clk); #2; start = 1'b0;
    end
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(negedge clk); #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; init_val = '0; act_mask = '0; rep_mask = '0;
    use_det = 1'b0; pin_en = 1'b0; pin_exp = '0; last_exp = '0;
    repeat (2) @(negedge clk);
    #2; rst = 1'b0;
    @(negedge clk); #2;

    // empty network: 0xFF is already a fixed point
    set_pin(8'hFF, 0, 8'hFF, 1'b0, 1'b1, 1'b0);
    go(8'hFF, 1'b0, 1'b0);
    // empty network from 0xA5: one step to 0xFF
    set_pin(8'hFF, 1, 8'hA5, 1'b0, 1'b1, 1'b0);
    go(8'hA5, 1'b0, 1'b0);
    // gene0 self-repressor oscillates 0xFF/0xFE
    rep_mask = 64'h1;
    set_pin(8'hFF, 3, 8'h00, 1'b1, 1'b0, 1'b0);
    go(8'h00, 1'b1, 1'b0);
    set_pin(8'hFF, 15, 8'h00, 1'b0, 1'b0, 1'b1);
    go(8'h00, 1'b0, 1'b0);
    // repeated init with a start poke while busy
    rep_mask = '0;
    set_pin(8'hFF, 1, 8'h3C, 1'b0, 1'b1, 1'b0);
    go(8'h3C, 1'b0, 1'b1);
    go(8'h3C, 1'b0, 1'b1);

    // reset in RUN at cnt=5
    rep_mask = 64'h1;
    pin_en = 1'b0;
    init_val = 8'h00;
    use_det = 1'b0;
    build_run(8'h00, 1'b0);
    start = 1'b1;
    @(negedge clk); #2; start = 1'b0;
    repeat (7) @(negedge clk);
    #2; rst = 1'b1;
    last_exp = '0;
    @(negedge clk); #2; rst = 1'b0;
    @(negedge clk); #2;
    rep_mask = '0;
    set_pin(8'hFF, 1, 8'hA5, 1'b0, 1'b1, 1'b0);
    go(8'hA5, 1'b0, 1'b0);

    pin_en = 1'b0;
    for (int r = 0; r < 40; r++) begin
      act_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      rep_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      go(N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
